// File: rtl/cordic_log_prenorm.sv
// Normalises an unsigned integer x into mantissa m in [1.0, 2.0) and exponent e
// with x = m * 2^e, ahead of the CORDIC log stage. Three-stage pipeline, no backpressure.
module cordic_log_prenorm #(
  parameter int unsigned WD   = 32,
  parameter int unsigned FRAC = WD - 2,
  parameter int unsigned EW   = $clog2(WD) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid_in,
  input  logic [WD-1:0] i_data_in,
  output logic [WD-1:0] o_mant,
  output logic [EW-1:0] o_exp,
  output logic          o_zero,
  output logic          o_valid_out
);

  localparam int unsigned NG = (WD + 7) / 8;
  localparam int unsigned XW = NG * 8;
  localparam int unsigned PW = (WD > 1) ? $clog2(WD) : 1;

  logic [2:0]           vld;
  logic [WD-1:0]        x1;
  logic [NG-1:0]        nz1;
  logic [NG-1:0][2:0]   idx1;
  logic [WD-1:0]        x2;
  logic [PW-1:0]        p2;
  logic                 z2;

  logic [XW-1:0]        xpad_c;
  logic [NG-1:0]        grp_nz_c;
  logic [NG-1:0][2:0]   grp_idx_c;
  logic [PW-1:0]        p_c;
  logic                 zero_c;
  logic [WD-1:0]        mant_c;

  assign o_valid_out = vld[2];

  // Stage 1 lookahead: per-byte nonzero flag and local leading-one index
  always_comb begin
    xpad_c    = XW'(i_data_in);
    grp_nz_c  = '0;
    grp_idx_c = '0;
    for (int g = 0; g < int'(NG); g++) begin
      grp_nz_c[g] = |xpad_c[g*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        if (xpad_c[g*8+b]) grp_idx_c[g] = 3'(b);
      end
    end
  end

  // Stage 2: the highest nonzero byte wins; ascending scan lets later groups override
  always_comb begin
    p_c    = '0;
    zero_c = ~|nz1;
    for (int g = 0; g < int'(NG); g++) begin
      if (nz1[g]) p_c = PW'(g * 8 + int'(idx1[g]));
    end
  end

  // Stage 3: move the leading one onto bit FRAC; right shifts truncate
  always_comb begin
    mant_c = '0;
    if (p2 <= PW'(FRAC)) mant_c = x2 << (PW'(FRAC) - p2);
    else                 mant_c = x2 >> (p2 - PW'(FRAC));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld    <= '0;
      x1     <= '0;
      nz1    <= '0;
      idx1   <= '0;
      x2     <= '0;
      p2     <= '0;
      z2     <= 1'b0;
      o_mant <= '0;
      o_exp  <= '0;
      o_zero <= 1'b0;
    end else begin
      vld <= {vld[1:0], i_valid_in};
      if (i_valid_in) begin
        x1   <= i_data_in;
        nz1  <= grp_nz_c;
        idx1 <= grp_idx_c;
      end
      if (vld[0]) begin
        x2 <= x1;
        p2 <= p_c;
        z2 <= zero_c;
      end
      if (vld[1]) begin
        if (z2) begin
          o_mant <= WD'(1) << FRAC;
          o_exp  <= '0;
          o_zero <= 1'b1;
        end else begin
          o_mant <= mant_c;
          o_exp  <= EW'(p2);
          o_zero <= 1'b0;
        end
      end
    end
  end

endmodule
